acc_collect: RTL and testbench

Result collector that sits downstream of the pipelined multiply-add datapath. It consumes the signed 16-bit result stream qualified by a valid strobe and sums every `LEN` consecutive valid samples into a wider accumulator. Each completed sum goes into a single-entry output register with a valid/ready handshake. The upstream datapath cannot be stalled, so the block never back-pressures its input: a completed sum that finds the output register occupied is dropped and flagged.

---
 rtl/acc_collect_if.sv | 24 ++
 rtl/acc_collect.sv | 128 ++++++++++++
 tb/tb_acc_collect.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/acc_collect_if.sv
// acc_collect port bundle: sample stream in, handshaked sum out.
// master drives the stream and rdy_in; slave is the collector.
interface acc_collect_if #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24
);
  logic signed [IN_W-1:0]  s_in;
  logic                    val_in;
  logic signed [ACC_W-1:0] acc_out;
  logic                    val_out;
  logic                    rdy_in;
  logic                    drop;
  logic                    sat;

  modport master (
    output s_in, val_in, rdy_in,
    input  acc_out, val_out, drop, sat
  );

  modport slave (
    input  s_in, val_in, rdy_in,
    output acc_out, val_out, drop, sat
  );
endinterface

// File: rtl/acc_collect.sv
// Sums every LEN valid samples into a single-entry handshaked output.
// Optional clamping arithmetic with sticky sat flag: `define ACC_SAT_EN.
module acc_collect #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24,
  parameter int LEN   = 8
) (
  input  logic         clk,
  input  logic         rst,
  acc_collect_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_e;

  localparam logic [7:0] LAST = 8'(LEN - 1);

  state_e                  st_q, st_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] out_q, out_d;
  logic signed [ACC_W-1:0] sx, sum;
  logic [7:0]              cnt_q, cnt_d;
  logic                    drop_q, drop_d;
  logic                    sat_q, sat_d;
  logic                    done, blk_sat;

  assign sx   = ACC_W'(bus.s_in);
  assign done = bus.val_in && (cnt_q == LAST);

`ifdef ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] MAXV =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV =
    {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] wide;
  logic           ovf;
  logic           sticky_q, sticky_d;

  // One guard bit: top two bits disagree on overflow.
  assign wide = {acc_q[ACC_W-1], acc_q}
              + {sx[ACC_W-1], sx};
  assign ovf  = wide[ACC_W] ^ wide[ACC_W-1];
  assign sum  = !ovf ? wide[ACC_W-1:0]
              : (wide[ACC_W] ? MINV : MAXV);
  assign blk_sat = sticky_q | ovf;

  always_comb begin
    sticky_d = sticky_q;
    if (bus.val_in) begin
      sticky_d = done ? 1'b0 : blk_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end
`else
  assign sum     = acc_q + sx;
  assign blk_sat = 1'b0;
`endif

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (bus.val_in) begin
      if (done) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    st_d   = st_q;
    out_d  = out_q;
    sat_d  = sat_q;
    drop_d = 1'b0;
    unique case (st_q)
      EMPTY: begin
        if (done) begin
          out_d = sum;
          sat_d = blk_sat;
          st_d  = FULL;
        end
      end
      FULL: begin
        if (done && bus.rdy_in) begin
          out_d = sum;
          sat_d = blk_sat;
        end else if (done) begin
          drop_d = 1'b1;
        end else if (bus.rdy_in) begin
          st_d = EMPTY;
        end
      end
      default: st_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= EMPTY;
      acc_q  <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      sat_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      sat_q  <= sat_d;
      drop_q <= drop_d;
    end
  end

  assign bus.acc_out = out_q;
  assign bus.val_out = (st_q == FULL);
  assign bus.drop    = drop_q;
  assign bus.sat     = sat_q;
endmodule

// File: tb/tb_acc_collect.sv
// Directed bench for acc_collect across LEN/ACC_W variants.
// Expected sat results follow ACC_SAT_EN.
module tb_acc_collect;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  acc_collect_if #(.IN_W(16), .ACC_W(24)) b4 ();
  acc_collect_if #(.IN_W(16), .ACC_W(24)) b2 ();
  acc_collect_if #(.IN_W(16), .ACC_W(16)) b16 ();
  acc_collect_if #(.IN_W(16), .ACC_W(24)) b1 ();

  acc_collect #(.IN_W(16), .ACC_W(24), .LEN(4)) u4 (
    .clk(clk), .rst(rst), .bus(b4)
  );
  acc_collect #(.IN_W(16), .ACC_W(24), .LEN(2)) u2 (
    .clk(clk), .rst(rst), .bus(b2)
  );
  acc_collect #(.IN_W(16), .ACC_W(16), .LEN(4)) u16 (
    .clk(clk), .rst(rst), .bus(b16)
  );
  acc_collect #(.IN_W(16), .ACC_W(24), .LEN(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  task automatic chk(input string tag,
                     input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int sat_hi;
  int acc_hi;

  initial begin
`ifdef ACC_SAT_EN
    sat_hi = 1;
    acc_hi = 32767;
`else
    sat_hi = 0;
    acc_hi = 0;
`endif
    b4.val_in = 0;  b4.s_in = '0;  b4.rdy_in = 0;
    b2.val_in = 0;  b2.s_in = '0;  b2.rdy_in = 0;
    b16.val_in = 0; b16.s_in = '0; b16.rdy_in = 0;
    b1.val_in = 0;  b1.s_in = '0;  b1.rdy_in = 0;

    step(); step();
    chk("rst_acc", int'(b4.acc_out), 0);
    chk("rst_val", int'(b4.val_out), 0);
    chk("rst_drop", int'(b4.drop), 0);
    chk("rst_sat", int'(b4.sat), 0);
    chk("rst_val2", int'(b2.val_out), 0);
    rst = 0;

    // LEN=4 back-to-back, rdy held high
    b4.rdy_in = 1;
    for (int i = 1; i <= 4; i++) begin
      b4.val_in = 1;
      b4.s_in = 16'(i * 100);
      step();
      if (i < 4) chk("a_vpre", int'(b4.val_out), 0);
    end
    chk("a_acc", int'(b4.acc_out), 1000);
    chk("a_val", int'(b4.val_out), 1);
    b4.val_in = 0;
    step();
    chk("a_vpost", int'(b4.val_out), 0);

    // same stream with 2-cycle gaps
    for (int i = 1; i <= 4; i++) begin
      b4.val_in = 1;
      b4.s_in = 16'(i * 100);
      step();
      if (i == 4) begin
        chk("g_acc", int'(b4.acc_out), 1000);
        chk("g_val", int'(b4.val_out), 1);
      end else begin
        chk("g_vpre", int'(b4.val_out), 0);
      end
      b4.val_in = 0;
      step(); step();
    end

    // negative sign extension
    for (int i = 0; i < 4; i++) begin
      b4.val_in = 1;
      b4.s_in = -16'sd16384;
      step();
    end
    chk("n_acc", int'(b4.acc_out), -65536);
    chk("n_raw", int'({8'h00, b4.acc_out}),
        32'h00FF_0000);
    b4.val_in = 0;
    step();

    // LEN=2 overflow of output register
    b2.rdy_in = 0;
    for (int i = 1; i <= 4; i++) begin
      b2.val_in = 1;
      b2.s_in = 16'(i);
      step();
      if (i == 2) begin
        chk("d_acc2", int'(b2.acc_out), 3);
        chk("d_val2", int'(b2.val_out), 1);
      end
      if (i == 3) chk("d_drop3", int'(b2.drop), 0);
    end
    chk("d_drop", int'(b2.drop), 1);
    chk("d_hold", int'(b2.acc_out), 3);
    b2.val_in = 0;
    step();
    chk("d_drop_end", int'(b2.drop), 0);
    chk("d_val", int'(b2.val_out), 1);
    chk("d_acc", int'(b2.acc_out), 3);
    b2.rdy_in = 1;
    step();
    chk("d_vfall", int'(b2.val_out), 0);

    // completion and handshake on the same edge
    b2.rdy_in = 0;
    for (int i = 1; i <= 4; i++) begin
      b2.val_in = 1;
      b2.s_in = 16'(i);
      b2.rdy_in = (i == 4);
      step();
      if (i == 2) chk("s_acc3", int'(b2.acc_out), 3);
    end
    chk("s_acc7", int'(b2.acc_out), 7);
    chk("s_val", int'(b2.val_out), 1);
    chk("s_drop", int'(b2.drop), 0);
    b2.val_in = 0;
    step();
    chk("s_vfall", int'(b2.val_out), 0);

    // ACC_W=16 overflow
    b16.rdy_in = 1;
    for (int i = 0; i < 4; i++) begin
      b16.val_in = 1;
      b16.s_in = 16'sd16384;
      step();
    end
    chk("o_acc", int'(b16.acc_out), acc_hi);
    chk("o_sat", int'(b16.sat), sat_hi);
    chk("o_val", int'(b16.val_out), 1);
    for (int i = 0; i < 4; i++) begin
      b16.s_in = 16'sd1;
      step();
    end
    chk("o2_acc", int'(b16.acc_out), 4);
    chk("o2_sat", int'(b16.sat), 0);
    b16.val_in = 0;
    step();

    // LEN=1: every sample completes
    b1.rdy_in = 0;
    b1.val_in = 1;
    b1.s_in = -16'sd5;
    step();
    chk("l1_acc", int'(b1.acc_out), -5);
    chk("l1_val", int'(b1.val_out), 1);
    b1.s_in = 16'sd7;
    b1.rdy_in = 1;
    step();
    chk("l1_acc2", int'(b1.acc_out), 7);
    b1.val_in = 0;
    step();
    chk("l1_vfall", int'(b1.val_out), 0);

    // reset mid-block with a pending output
    b4.rdy_in = 0;
    for (int i = 0; i < 4; i++) begin
      b4.val_in = 1;
      b4.s_in = 16'sd1;
      step();
    end
    chk("r_pend", int'(b4.acc_out), 4);
    for (int i = 0; i < 2; i++) begin
      b4.s_in = 16'sd50;
      step();
    end
    b4.val_in = 0;
    rst = 1;
    step();
    chk("r_acc", int'(b4.acc_out), 0);
    chk("r_val", int'(b4.val_out), 0);
    chk("r_drop", int'(b4.drop), 0);
    chk("r_sat", int'(b4.sat), 0);
    rst = 0;
    b4.rdy_in = 1;
    for (int i = 1; i <= 4; i++) begin
      b4.val_in = 1;
      b4.s_in = 16'(i);
      step();
    end
    chk("r_acc10", int'(b4.acc_out), 10);
    chk("r_val10", int'(b4.val_out), 1);
    b4.val_in = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
